// File: rtl/integrator_pkg.sv
// ============================================================================
// Module : integrator_pkg
// Brief  : Shared saturation limits and result type for the integrator.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package integrator_pkg;

  // Widest LENGTH the shared result type can carry; LENGTH must stay within 2..31.
  localparam int c_MAX_LENGTH = 32;

  typedef struct packed {
    logic [c_MAX_LENGTH-1:0] value;
    logic                    ovf;
    logic                    unf;
  } sat_result_t;

  function automatic int sat_max(input int len);
    return (1 << (len - 1)) - 1;
  endfunction

  function automatic int sat_min(input int len);
    return -(1 << (len - 1));
  endfunction

endpackage

`default_nettype wire

// File: rtl/integrator_sat_add.sv
// ============================================================================
// Module : integrator_sat_add
// Brief  : Combinational signed add with clip to the LENGTH-bit range.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module integrator_sat_add
  import integrator_pkg::*;
#(
  parameter int LENGTH = 5
) (
  input  logic signed [LENGTH-1:0] i_acc,
  input  logic signed [LENGTH-1:0] i_x,
  output logic signed [LENGTH-1:0] o_value,
  output logic                     o_ovf,
  output logic                     o_unf
);

  localparam logic signed [LENGTH:0] c_MAX = (LENGTH + 1)'(sat_max(LENGTH));
  localparam logic signed [LENGTH:0] c_MIN = (LENGTH + 1)'(sat_min(LENGTH));

  logic signed [LENGTH:0] w_sum;
  sat_result_t            w_res;
  logic                   w_unused_hi;

  // One guard bit is enough: the sum of two LENGTH-bit operands cannot wrap.
  assign w_sum = {i_acc[LENGTH-1], i_acc} + {i_x[LENGTH-1], i_x};

  always_comb begin
    w_res = '0;
    if (w_sum > c_MAX) begin
      w_res.value[LENGTH-1:0] = c_MAX[LENGTH-1:0];
      w_res.ovf               = 1'b1;
    end else if (w_sum < c_MIN) begin
      w_res.value[LENGTH-1:0] = c_MIN[LENGTH-1:0];
      w_res.unf               = 1'b1;
    end else begin
      w_res.value[LENGTH-1:0] = w_sum[LENGTH-1:0];
    end
  end

  assign o_value     = w_res.value[LENGTH-1:0];
  assign o_ovf       = w_res.ovf;
  assign o_unf       = w_res.unf;
  assign w_unused_hi = ^w_res.value[c_MAX_LENGTH-1:LENGTH];

endmodule

`default_nettype wire

// File: rtl/integrator_back.sv
// ============================================================================
// Module : integrator_back
// Brief  : Backward-Euler saturating integrator with optional input register.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module integrator_back
  import integrator_pkg::*;
#(
  parameter int LENGTH    = 5,
  parameter bit INPUT_REG = 1'b1
) (
  input  logic                     CLK_I,
  input  logic                     RST_I,
  input  logic signed [LENGTH-1:0] DATA_I,
  output logic signed [LENGTH-1:0] DATA_O,
  output logic                     OFDET_O,
  output logic                     UFDET_O
);

  logic signed [LENGTH-1:0] w_x;
  logic signed [LENGTH-1:0] w_value;
  logic                     w_ovf;
  logic                     w_unf;
  logic signed [LENGTH-1:0] r_acc;
  logic                     r_ovf;
  logic                     r_unf;

  generate
    if (INPUT_REG) begin : g_input_reg
      logic signed [LENGTH-1:0] r_x;

      always_ff @(posedge CLK_I) begin
        if (RST_I) begin
          r_x <= '0;
        end else begin
          r_x <= DATA_I;
        end
      end

      assign w_x = r_x;
    end else begin : g_input_direct
      assign w_x = DATA_I;
    end
  endgenerate

  integrator_sat_add #(
    .LENGTH (LENGTH)
  ) u_sat_add (
    .i_acc   (r_acc),
    .i_x     (w_x),
    .o_value (w_value),
    .o_ovf   (w_ovf),
    .o_unf   (w_unf)
  );

  // Flags are rewritten every cycle so they describe only the current output.
  always_ff @(posedge CLK_I) begin
    if (RST_I) begin
      r_acc <= '0;
      r_ovf <= 1'b0;
      r_unf <= 1'b0;
    end else begin
      r_acc <= w_value;
      r_ovf <= w_ovf;
      r_unf <= w_unf;
    end
  end

  assign DATA_O  = r_acc;
  assign OFDET_O = r_ovf;
  assign UFDET_O = r_unf;

endmodule

`default_nettype wire

// File: tb/tb_integrator_back.sv
// ============================================================================
// Module : tb_integrator_back
// Brief  : Directed checks of integrator_back with and without input register.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_integrator_back;

  logic              clk = 1'b0;
  logic              rst;
  logic signed [4:0] din;
  logic signed [4:0] a_data, b_data;
  logic              a_of, a_uf, b_of, b_uf;
  int                checks   = 0;
  int                failures = 0;

  always #5 clk = ~clk;

  integrator_back #(.LENGTH(5), .INPUT_REG(1'b1)) u_dut_reg (
    .CLK_I(clk), .RST_I(rst), .DATA_I(din),
    .DATA_O(a_data), .OFDET_O(a_of), .UFDET_O(a_uf)
  );

  integrator_back #(.LENGTH(5), .INPUT_REG(1'b0)) u_dut_comb (
    .CLK_I(clk), .RST_I(rst), .DATA_I(din),
    .DATA_O(b_data), .OFDET_O(b_of), .UFDET_O(b_uf)
  );

  // Advance one edge, then sample away from it; flag exclusivity is checked every cycle.
  task automatic tick();
    @(posedge clk);
    #1;
    checks++;
    assert (!((a_of && a_uf) || (b_of && b_uf)))
    else begin
      failures++;
      $display("FAIL flags_exclusive observed=%b%b%b%b required_not_both_high",
               a_of, a_uf, b_of, b_uf);
      $error("flags_exclusive");
    end
  endtask

  task automatic chk_a(input string tag, input int e_data, input bit e_of, input bit e_uf);
    logic [6:0] obs, exp;
    obs = {a_data, a_of, a_uf};
    exp = {5'(e_data), e_of, e_uf};
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $display("FAIL %s (reg) observed data=%0d of=%b uf=%b expected data=%0d of=%b uf=%b",
               tag, a_data, a_of, a_uf, e_data, e_of, e_uf);
      $error("%s", tag);
    end
  endtask

  task automatic chk_b(input string tag, input int e_data, input bit e_of, input bit e_uf);
    logic [6:0] obs, exp;
    obs = {b_data, b_of, b_uf};
    exp = {5'(e_data), e_of, e_uf};
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $display("FAIL %s (comb) observed data=%0d of=%b uf=%b expected data=%0d of=%b uf=%b",
               tag, b_data, b_of, b_uf, e_data, e_of, e_uf);
      $error("%s", tag);
    end
  endtask

  initial begin
    rst = 1'b1;
    din = 5'sd0;
    tick();
    tick();
    chk_a("reset_init", 0, 0, 0);
    chk_b("reset_init", 0, 0, 0);

    // Positive ramp from reset, exact hit of +15 then clipping.
    rst = 1'b0;
    din = 5'sd1;
    for (int i = 0; i <= 15; i++) begin
      tick();
      chk_a("pos_ramp", i, 0, 0);
      chk_b("pos_ramp", (i + 1 > 15) ? 15 : i + 1, (i + 1 > 15), 0);
    end
    tick();
    chk_a("pos_clip", 15, 1, 0);
    chk_b("pos_clip", 15, 1, 0);
    tick();
    chk_a("pos_clip_hold", 15, 1, 0);

    // Recovery: the +1 already in the input register still clips once.
    din = -5'sd1;
    tick();
    chk_a("recover_first", 15, 1, 0);
    chk_b("recover_first", 14, 0, 0);
    for (int k = 0; k <= 30; k++) begin
      tick();
      chk_a("recover_ramp", 14 - k, 0, 0);
    end
    tick();
    chk_a("neg_clip", -16, 0, 1);
    tick();
    chk_a("neg_clip_hold", -16, 0, 1);

    // Mid-run reset with -1 held in the input register, then a +5 impulse.
    rst = 1'b1;
    tick();
    chk_a("reset_mid", 0, 0, 0);
    chk_b("reset_mid", 0, 0, 0);
    rst = 1'b0;
    din = 5'sd5;
    tick();
    chk_a("impulse_e1", 0, 0, 0);
    chk_b("impulse_e1", 5, 0, 0);
    din = 5'sd0;
    tick();
    chk_a("impulse_e2", 5, 0, 0);
    chk_b("impulse_e2", 5, 0, 0);
    tick();
    chk_a("impulse_e3", 5, 0, 0);

    // Negative ramp from reset down to an exact -16, then clipping.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    din = -5'sd1;
    for (int i = 0; i <= 16; i++) begin
      tick();
      chk_a("neg_ramp", -i, 0, 0);
    end
    tick();
    chk_a("neg_ramp_clip", -16, 0, 1);
    tick();
    chk_a("neg_ramp_hold", -16, 0, 1);

    // Large step: -16 arriving while the output sits at -3.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    din = -5'sd1;
    tick();
    chk_a("step_ramp0", 0, 0, 0);
    tick();
    chk_a("step_ramp1", -1, 0, 0);
    tick();
    chk_a("step_ramp2", -2, 0, 0);
    din = -5'sd16;
    tick();
    chk_a("step_pre", -3, 0, 0);
    tick();
    chk_a("step_clip", -16, 0, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
